// File: rtl/gc_sched_pkg.sv
// gc_sched_pkg: shared types and constants for the garbled-gate scheduler
// FREE_XOR_SKIP_EN: when defined, XOR/XNOR gates write back a label but produce no table.
package gc_sched_pkg;
  localparam int GC_S = 20;
  localparam int GC_K = 128;
  localparam int GC_A = 10;
  localparam int GC_NR_AES = 10;
  localparam logic [3:0] G_XOR = 4'b0110;
  localparam logic [3:0] G_XNOR = 4'b1001;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic valid;
    logic [GC_A-1:0] out_addr;
    logic [GC_S-1:0] gid;
    logic [3:0] g_logic;
  } infl_t;
  function automatic logic needs_table(infl_t e);
`ifdef FREE_XOR_SKIP_EN
    return e.valid && e.g_logic != G_XOR && e.g_logic != G_XNOR;
`else
    return e.valid;
`endif
  endfunction
endpackage

// File: rtl/gc_table_fifo.sv
// gc_table_fifo: first-word-fall-through FIFO of garbled tables with occupancy count
// ports: push/wdata write side, pop/rdata head (valid while count != 0), count occupancy
module gc_table_fifo #(
  parameter int D = 16,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [$clog2(D):0] count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= wdata;
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == (AW+1)'(D)));
endmodule

// File: rtl/gc_gate_scheduler.sv
// gc_gate_scheduler: issues garbled gates to the GC engine, writes labels back, streams tables
// ports: start/cid_in/num_gates/busy/done run control; gate_* descriptor stream (valid/ready);
//        lbl_* wire-label RAM (1-cycle read); eng_* GC engine (latency LAT); tbl_* table stream.
// FREE_XOR_SKIP_EN: when defined, XOR/XNOR gates push no table and take no FIFO credit.
module gc_gate_scheduler
  import gc_sched_pkg::*;
#(
  parameter int S = GC_S,
  parameter int K = GC_K,
  parameter int A = GC_A,
  parameter int LAT = GC_NR_AES + 1,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [S-1:0] cid_in,
  input  logic [S-1:0] num_gates,
  output logic         busy,
  output logic         done,
  input  logic         gate_valid,
  output logic         gate_ready,
  input  logic [A-1:0] gate_in0_addr,
  input  logic [A-1:0] gate_in1_addr,
  input  logic [A-1:0] gate_out_addr,
  input  logic [3:0]   gate_logic,
  output logic [A-1:0] lbl_rd_addr0,
  output logic [A-1:0] lbl_rd_addr1,
  input  logic [K-1:0] lbl_rd_data0,
  input  logic [K-1:0] lbl_rd_data1,
  output logic         lbl_wr_en,
  output logic [A-1:0] lbl_wr_addr,
  output logic [K-1:0] lbl_wr_data,
  output logic [S-1:0] eng_cid,
  output logic [S-1:0] eng_gid,
  output logic [3:0]   eng_g_logic,
  output logic [K-1:0] eng_in0_label,
  output logic [K-1:0] eng_in1_label,
  input  logic [K-1:0] eng_t0,
  input  logic [K-1:0] eng_t1,
  input  logic [K-1:0] eng_out_label,
  output logic         tbl_valid,
  input  logic         tbl_ready,
  output logic [S-1:0] tbl_gid,
  output logic [K-1:0] tbl_t0,
  output logic [K-1:0] tbl_t1
);
  localparam int FW = $clog2(D) + 1;
  localparam int CW = $clog2(D + LAT + 2) + 1;
  state_t state;
  logic [S-1:0] cid_q, n_q, issued, gid_q;
  infl_t pipe [LAT+1];
  infl_t wb;
  logic hazard, any_infl, accept;
  logic [CW-1:0] credits;
  logic [FW-1:0] fifo_cnt;
  logic [S+2*K-1:0] head;
  assign wb = pipe[LAT];
  assign accept = gate_valid && gate_ready;
  assign busy = state != IDLE;
  // credits: tables that will land in the FIFO; the engine cannot stall, so reserve space at issue
  assign gate_ready = state == RUN && !hazard && CW'(fifo_cnt) + credits + CW'(1) <= CW'(D);
  assign lbl_rd_addr0 = accept ? gate_in0_addr : '0;
  assign lbl_rd_addr1 = accept ? gate_in1_addr : '0;
  assign eng_cid = cid_q;
  assign eng_gid = gid_q;
  assign eng_g_logic = pipe[0].g_logic;
  assign eng_in0_label = pipe[0].valid ? lbl_rd_data0 : '0;
  assign eng_in1_label = pipe[0].valid ? lbl_rd_data1 : '0;
  assign lbl_wr_en = wb.valid;
  assign lbl_wr_addr = wb.out_addr;
  assign lbl_wr_data = wb.valid ? eng_out_label : '0;
  assign tbl_valid = fifo_cnt != '0;
  assign {tbl_gid, tbl_t0, tbl_t1} = tbl_valid ? head : '0;
  // hazard includes the writeback stage, so a dependent read lands the cycle after the write
  always_comb begin
    hazard = 1'b0;
    any_infl = 1'b0;
    credits = '0;
    for (int i = 0; i <= LAT; i++) begin
      hazard = hazard || (pipe[i].valid && (pipe[i].out_addr == gate_in0_addr || pipe[i].out_addr == gate_in1_addr));
      any_infl = any_infl || pipe[i].valid;
      credits = credits + CW'(needs_table(pipe[i]));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= accept ? infl_t'{valid: 1'b1, out_addr: gate_out_addr, gid: issued, g_logic: gate_logic} : '0;
      for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      cid_q <= '0;
      n_q <= '0;
      issued <= '0;
      gid_q <= '0;
    end else begin
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          cid_q <= cid_in;
          n_q <= num_gates;
          issued <= '0;
          state <= num_gates == '0 ? DONE : RUN;
        end
        RUN: if (accept) begin
          issued <= issued + S'(1);
          gid_q <= issued;
          if (issued == n_q - S'(1)) state <= DRAIN;
        end
        DRAIN: if (!any_infl && !tbl_valid) state <= DONE;
        DONE: state <= IDLE;
      endcase
    end
  end
  gc_table_fifo #(.D(D), .W(S + 2*K)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(needs_table(wb)),
    .wdata({wb.gid, eng_t0, eng_t1}),
    .pop(tbl_valid && tbl_ready),
    .rdata(head),
    .count(fifo_cnt)
  );
endmodule

// File: tb/tb_gc_gate_scheduler.sv
// tb_gc_gate_scheduler: self-checking bench with RAM/engine models and a sequential gate reference
module tb_gc_gate_scheduler;
  localparam int S = 20, K = 128, A = 10, LAT = 11, D = 16;
`ifdef FREE_XOR_SKIP_EN
  localparam int XOR_TABLES = 1;
`else
  localparam int XOR_TABLES = 3;
`endif
  logic clk = 0, rst, start, busy, done, gate_valid, gate_ready, lbl_wr_en, tbl_valid, tbl_ready;
  logic [S-1:0] cid_in, num_gates, eng_cid, eng_gid, tbl_gid;
  logic [A-1:0] gate_in0_addr, gate_in1_addr, gate_out_addr, lbl_rd_addr0, lbl_rd_addr1, lbl_wr_addr;
  logic [3:0] gate_logic, eng_g_logic;
  logic [K-1:0] lbl_rd_data0, lbl_rd_data1, lbl_wr_data, eng_in0_label, eng_in1_label;
  logic [K-1:0] eng_t0, eng_t1, eng_out_label, tbl_t0, tbl_t1;
  gc_gate_scheduler #(.S(S), .K(K), .A(A), .LAT(LAT), .D(D)) dut (
    .clk(clk), .rst(rst), .start(start), .cid_in(cid_in), .num_gates(num_gates),
    .busy(busy), .done(done), .gate_valid(gate_valid), .gate_ready(gate_ready),
    .gate_in0_addr(gate_in0_addr), .gate_in1_addr(gate_in1_addr), .gate_out_addr(gate_out_addr),
    .gate_logic(gate_logic), .lbl_rd_addr0(lbl_rd_addr0), .lbl_rd_addr1(lbl_rd_addr1),
    .lbl_rd_data0(lbl_rd_data0), .lbl_rd_data1(lbl_rd_data1), .lbl_wr_en(lbl_wr_en),
    .lbl_wr_addr(lbl_wr_addr), .lbl_wr_data(lbl_wr_data), .eng_cid(eng_cid), .eng_gid(eng_gid),
    .eng_g_logic(eng_g_logic), .eng_in0_label(eng_in0_label), .eng_in1_label(eng_in1_label),
    .eng_t0(eng_t0), .eng_t1(eng_t1), .eng_out_label(eng_out_label), .tbl_valid(tbl_valid),
    .tbl_ready(tbl_ready), .tbl_gid(tbl_gid), .tbl_t0(tbl_t0), .tbl_t1(tbl_t1)
  );
  always #5 clk = ~clk;
  typedef struct {logic [A-1:0] i0, i1, o; logic [3:0] lg;} gate_t;
  typedef struct {gate_t g; int at;} vec_t;
  int errors = 0, checks = 0, cyc = 0, wr_cnt = 0, tb_cnt = 0;
  logic [A+K-1:0] exp_wr[$];
  logic [S+2*K-1:0] exp_tb[$];
  int acc_cyc[$], wr_cyc[$];
  gate_t gates[$];
  logic [K-1:0] ram [1<<A];
  logic [K-1:0] mram [1<<A];
  logic [3*K-1:0] eng_pipe [LAT];
  function automatic logic [K-1:0] init_lbl(int i);
    return {32'(i) * 32'h9e3779b1, 32'(i) ^ 32'hdeadbeef, ~(32'(i) * 32'h85ebca6b), 32'(i) + 32'h01234567};
  endfunction
  // stand-in garbling function: any deterministic mix of all engine inputs
  function automatic logic [3*K-1:0] eng_f(logic [S-1:0] c, logic [S-1:0] g, logic [3:0] lg, logic [K-1:0] a, logic [K-1:0] b);
    logic [K-1:0] o, t0, t1;
    o = a ^ {b[94:0], b[127:95]} ^ {c, g, lg, 84'h5a5};
    t0 = o + {a[63:0], b[63:0]};
    t1 = ~o ^ {lg, 124'h0} ^ {b[127:64], a[127:64]};
    return {o, t0, t1};
  endfunction
  function automatic bit skip(logic [3:0] lg);
`ifdef FREE_XOR_SKIP_EN
    return lg == 4'b0110 || lg == 4'b1001;
`else
    return 1'b0;
`endif
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < (1 << A); i++) ram[i] <= init_lbl(i);
    end else begin
      lbl_rd_data0 <= ram[lbl_rd_addr0];
      lbl_rd_data1 <= ram[lbl_rd_addr1];
      if (lbl_wr_en) ram[lbl_wr_addr] <= lbl_wr_data;
    end
  end
  always @(posedge clk) begin
    eng_pipe[0] <= eng_f(eng_cid, eng_gid, eng_g_logic, eng_in0_label, eng_in1_label);
    for (int i = 1; i < LAT; i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign {eng_out_label, eng_t0, eng_t1} = eng_pipe[LAT-1];
  always @(negedge clk) if (!rst) begin
    if (lbl_wr_en) begin
      checks++;
      wr_cnt++;
      wr_cyc.push_back(cyc);
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0h data %h, required no write", lbl_wr_addr, lbl_wr_data);
      end else if ({lbl_wr_addr, lbl_wr_data} !== exp_wr[0]) begin
        errors++;
        $display("FAIL wr_data: got %h required %h", {lbl_wr_addr, lbl_wr_data}, exp_wr[0]);
        void'(exp_wr.pop_front());
      end else void'(exp_wr.pop_front());
    end
    if (tbl_valid && tbl_ready) begin
      checks++;
      tb_cnt++;
      if (exp_tb.size() == 0) begin
        errors++;
        $display("FAIL tbl_unexpected: got gid %0h, required no table", tbl_gid);
      end else if ({tbl_gid, tbl_t0, tbl_t1} !== exp_tb[0]) begin
        errors++;
        $display("FAIL tbl_data: got %h required %h", {tbl_gid, tbl_t0, tbl_t1}, exp_tb[0]);
        void'(exp_tb.pop_front());
      end else void'(exp_tb.pop_front());
    end
  end
  task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask
  // reference: gates execute strictly in order against a plain label array
  task automatic expect_run(input logic [S-1:0] cid, input int n);
    logic [3*K-1:0] r;
    for (int i = 0; i < n; i++) begin
      r = eng_f(cid, S'(i), gates[i].lg, mram[gates[i].i0], mram[gates[i].i1]);
      exp_wr.push_back({gates[i].o, r[3*K-1:2*K]});
      mram[gates[i].o] = r[3*K-1:2*K];
      if (!skip(gates[i].lg)) exp_tb.push_back({S'(i), r[2*K-1:0]});
    end
  endtask
  task automatic drive_gate(input int i);
    gate_in0_addr = gates[i].i0;
    gate_in1_addr = gates[i].i1;
    gate_out_addr = gates[i].o;
    gate_logic = gates[i].lg;
  endtask
  task automatic run_gates(input logic [S-1:0] cid, input int n, input int stall, input bit rnd);
    int idx = 0, guard = 0, t0, bad = 0;
    bit acc, seen = 0;
    acc_cyc.delete();
    wr_cyc.delete();
    tb_cnt = 0;
    expect_run(cid, n);
    tbl_ready = stall == 0;
    cid_in = cid;
    num_gates = S'(n);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    t0 = cyc;
    while (idx < n && guard < 4000) begin
      gate_valid = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
      drive_gate(idx);
      if (rnd) tbl_ready = $urandom_range(0, 1) == 1;
      if (stall > 0 && cyc - t0 == stall) begin
        chk("credit_stop", idx, D);
        tbl_ready = 1;
      end
      start = rnd && guard == 5;
      cid_in = start ? ~cid : cid;
      num_gates = start ? S'(3) : S'(n);
      @(negedge clk);
      acc = gate_valid && gate_ready;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk);
      #1 idx += int'(acc);
      guard++;
    end
    gate_valid = 0;
    start = 0;
    chk("all_accepted", idx, n);
    while (!seen && guard < 8000) begin
      tbl_ready = rnd ? $urandom_range(0, 1) == 1 : 1'b1;
      @(negedge clk);
      seen = done;
      @(posedge clk);
      #1 guard++;
    end
    tbl_ready = 1;
    chk("done_seen", seen, 1);
    chk("writes_left", exp_wr.size(), 0);
    chk("tables_left", exp_tb.size(), 0);
    for (int i = 0; i < n; i++)
      if (i >= wr_cyc.size() || i >= acc_cyc.size() || wr_cyc[i] != acc_cyc[i] + LAT + 1) bad++;
    chk("wb_latency", bad, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t vt[12];
    int w0, idx;
    rst = 1; start = 0; cid_in = 0; num_gates = 0; gate_valid = 0; tbl_ready = 1;
    gate_in0_addr = 0; gate_in1_addr = 0; gate_out_addr = 0; gate_logic = 0;
    for (int i = 0; i < (1 << A); i++) mram[i] = init_lbl(i);
    for (int k = 0; k < 8; k++) vt[k] = '{'{A'(2*k), A'(2*k+1), A'(100+k), 4'b1000}, k};
    vt[8] = '{'{A'(107), A'(3), A'(108), 4'b1110}, 7 + LAT + 2};
    vt[9] = '{'{A'(20), A'(21), A'(109), 4'b0110}, 7 + LAT + 3};
    vt[10] = '{'{A'(108), A'(108), A'(110), 4'b0001}, 7 + 2*(LAT + 2)};
    vt[11] = '{'{A'(100), A'(109), A'(111), 4'b0111}, 7 + LAT + 3 + LAT + 2};
    repeat (3) @(posedge clk);
    #1 gate_valid = 1;
    gate_in0_addr = 5;
    gate_in1_addr = 6;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gate_ready", gate_ready, 0);
    chk("rst_rd_addr0", lbl_rd_addr0, 0);
    chk("rst_wr_en", lbl_wr_en, 0);
    chk("rst_tbl_valid", tbl_valid, 0);
    chk("rst_eng_gid", eng_gid, 0);
    chk("rst_eng_label", eng_in0_label, 0);
    chk("rst_tbl_t0", tbl_t0, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("idle_gate_ready", gate_ready, 0);
    chk("idle_rd_addr1", lbl_rd_addr1, 0);
    @(posedge clk);
    #1 gate_valid = 0;
    gates.delete();
    foreach (vt[k]) gates.push_back(vt[k].g);
    run_gates(20'h0abcd, 12, 0, 0);
    for (int i = 0; i < 12; i++)
      chk($sformatf("accept_cyc%0d", i), i < acc_cyc.size() ? acc_cyc[i] - acc_cyc[0] : -1, vt[i].at);
    gates.delete();
    for (int i = 0; i < 20; i++) gates.push_back('{A'(200 + 2*i), A'(201 + 2*i), A'(300 + i), 4'b1000});
    run_gates(20'h00777, 20, 40, 0);
    chk("bp_tables", tb_cnt, 20);
    w0 = wr_cnt;
    cid_in = 20'h00123;
    num_gates = 0;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("zero_done_early", done, 0);
    @(posedge clk);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("zero_done_once", done, 0);
    chk("zero_no_writes", wr_cnt - w0, 0);
    @(posedge clk);
    #1 gates.delete();
    for (int i = 0; i < 10; i++) gates.push_back('{A'(400 + i), A'(410 + i), A'(420 + i), 4'b0100});
    cid_in = 20'h00555;
    num_gates = 10;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    idx = 0;
    for (int g = 0; g < 50 && idx < 4; g++) begin
      gate_valid = 1;
      drive_gate(idx);
      @(negedge clk);
      if (gate_ready) idx++;
      @(posedge clk);
      #1;
    end
    gate_valid = 0;
    chk("rst_run_accepts", idx, 4);
    w0 = wr_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_tbl_valid", tbl_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", lbl_wr_en, 0);
    repeat (LAT + 4) @(posedge clk);
    #1 chk("midrst_no_writes", wr_cnt - w0, 0);
    gates.delete();
    for (int i = 0; i < 5; i++) gates.push_back('{A'(430 + i), A'(431 + i), A'(440 + i), 4'b0010});
    run_gates(20'h00999, 5, 0, 0);
    chk("post_rst_tables", tb_cnt, 5);
    gates.delete();
    gates.push_back('{A'(500), A'(501), A'(510), 4'b0110});
    gates.push_back('{A'(502), A'(503), A'(511), 4'b1000});
    gates.push_back('{A'(504), A'(505), A'(512), 4'b0110});
    run_gates(20'h00042, 3, 0, 0);
    chk("xor_tables", tb_cnt, XOR_TABLES);
    for (int r = 0; r < 6; r++) begin
      gates.delete();
      for (int i = 0; i < 30; i++)
        gates.push_back('{A'($urandom_range(0, 15)), A'($urandom_range(0, 15)), A'($urandom_range(0, 15)), 4'($urandom_range(0, 15))});
      run_gates(S'($urandom), 30, 0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
